pattern_gen: RTL and testbench
==============================

Name: pattern_gen

Overview:
- Parametrised successor to the fixed test-pattern logic in the HDMI top level. Produces one RGB pixel per clk_pix from the hdmi core's cx/cy and screen geometry.
- Selectable patterns: the legacy checker/gradient, colour bars, ramp, solid colour, bouncing box.
- Sits between the hdmi core's coordinate outputs and its rgb input. Mode changes take effect only at frame start.

Parameters:
- COORD_W, 10, width of cx/cy/geometry inputs
- BPC, 8, bits per colour channel (8..12)
- BOX_SIZE, 32, bouncing-box edge in pixels
- BOX_STEP, 1, box displacement per frame, both axes

Ports:
- clk_pix  in  1  pixel clock
- rst_in  in  1  synchronous, active-low reset
- cx  in  COORD_W  current frame x
- cy  in  COORD_W  current frame y
- screen_start_x  in  COORD_W  first active column
- screen_start_y  in  COORD_W  first active row
- screen_width  in  COORD_W  active width
- screen_height  in  COORD_W  active height
- mode_in  in  3  requested pattern
- solid_color  in  3*BPC  {r,g,b} for mode 3
- rgb  out  3*BPC  {r,g,b}, registered
- rgb_valid  out  1  registered: pixel in active area
- mode_active  out  3  mode currently applied
- frame_cnt  out  16  frames since reset, wraps

Behaviour:
- Clock and reset: one clock, clk_pix. Reset is synchronous and active-low on rst_in.
- Values at reset: rgb=0, rgb_valid=0, mode_active=0, frame_cnt=0, box at (0,0) moving +x,+y, bar state cleared.
- Active coordinates:
  - x = cx - screen_start_x, y = cy - screen_start_y, each COORD_W wide.
  - active = (cx >= screen_start_x) && (cy >= screen_start_y).
- Latency: rgb and rgb_valid reflect the cx/cy of the previous cycle (exactly 1 cycle).
- Blanking: when the pixel is not active, rgb is 0 for every mode.
- Frame start event (fs) = (cx==0 && cy==0). On fs:
  - mode_active <= mode_in (value 6 or 7 maps to 0).
  - frame_cnt <= frame_cnt + 1.
  - Box position updates.
  - fs is evaluated every cycle; back-to-back fs cycles each count.
- Mode 0, legacy. Uses raw cx/cy; the 8-bit result is left-aligned in BPC, with low BPC-8 bits zero:
  - r = {cx[5:0] & {6{cy[4:3]==~cx[4:3]}}, 2'b00}
  - g = cx[7:0] & {8{cy[6]}}
  - b = cy[7:0]
- Mode 1, eight vertical bars, in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Bar width bw = screen_width>>3.
  - A run counter resets at x==0 and advances the bar index each time it reaches bw.
  - Index saturates at 7; the last bar absorbs any remainder. No divider.
  - If bw==0, the whole line is bar 7.
- Mode 2: r=g=b=x[BPC-1:0], wrapping.
- Mode 3: rgb = solid_color.
- Mode 4: white BOX_SIZE square on black at (bx,by).
  - Inside when bx <= x < bx+BOX_SIZE and by <= y < by+BOX_SIZE.
  - On fs, per axis: if moving + and pos+BOX_SIZE+BOX_STEP > extent (screen_width or screen_height), reverse and set pos -= BOX_STEP. If moving - and pos < BOX_STEP, reverse and set pos += BOX_STEP. Otherwise pos += or -= BOX_STEP.
  - Position is updated in all modes, so the box is continuous across mode switches.
- Arithmetic: box comparisons use COORD_W+1 bits so there is no wrap.
- Mid-frame reset: all state returns to its reset value; output resumes at the next cycle after rst_in goes high.
- mode_in is ignored except on fs.

Decomposition:
- Package pattern_pkg:
  - mode enum (PAT_LEGACY=0, PAT_BARS, PAT_RAMP, PAT_SOLID, PAT_BOX)
  - 8-entry bar colour constant table, in 8-bit {r,g,b}, widened by left-alignment
  - rgb struct typedef parametrised by BPC via localparam
- One sub-module, pattern_box_mover: owns bx, by and the direction registers, advanced by fs. Everything else stays in pattern_gen.

Test Plan (screen_start 160/45, screen 640x480, BPC=8 unless stated):
- Legacy: mode 0. cx=200, cy=72 -> next cycle rgb=0x00C848, rgb_valid=1. cx=208, cy=72 -> rgb=0x40D048.
- Bars: mode 1. cx=239, cy=100 -> 0xFFFFFF. cx=240 -> 0xFFFF00. cx=799 -> 0x000000. cx=100 (blanking) -> rgb=0, rgb_valid=0.
- Mode latch: mode 0 applied. mode_in=3 with solid 0x123456 at cy=100 -> rgb unchanged until the next fs; first active pixel after it = 0x123456; mode_active=3. mode_in=7 -> mode_active=0.
- Box bounce: mode 4, BOX_STEP=1.
  - After 3 fs: bx=by=3; pixel (x=3,y=3) is white, (x=2,y=3) is black.
  - Force bx=608 moving + -> next fs: bx=607, direction -.
- Reset: assert rst_in=0 for 2 cycles mid-frame with frame_cnt=5, mode 4 -> rgb=0, rgb_valid=0, frame_cnt=0, box (0,0), mode_active=0.
- BPC=10: mode 0 at cx=200, cy=72 -> r=0, g=0xC8<<2=0x320, b=0x48<<2=0x120.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types for the test-pattern generator: pattern modes, box direction,
// and the colour-bar table.
`default_nettype none

package pattern_pkg;

    typedef enum logic [2:0] {
        PAT_LEGACY = 3'd0,
        PAT_BARS   = 3'd1,
        PAT_RAMP   = 3'd2,
        PAT_SOLID  = 3'd3,
        PAT_BOX    = 3'd4
    } pat_mode_e;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } box_dir_e;

    localparam int BAR_BPC  = 8;
    localparam int NUM_BARS = 8;

    typedef struct packed {
        logic [BAR_BPC-1:0] r;
        logic [BAR_BPC-1:0] g;
        logic [BAR_BPC-1:0] b;
    } bar_rgb_t;

    // Index 0 (white) is the least significant entry, index 7 (black) the most.
    localparam bar_rgb_t [NUM_BARS-1:0] BAR_TABLE = {
        24'h000000,  // black
        24'h0000FF,  // blue
        24'hFF0000,  // red
        24'hFF00FF,  // magenta
        24'h00FF00,  // green
        24'h00FFFF,  // cyan
        24'hFFFF00,  // yellow
        24'hFFFFFF   // white
    };

    // Codes 6 and 7 fall back to the legacy pattern.
    function automatic logic [2:0] map_mode(input logic [2:0] m);
        return ((m == 3'd6) || (m == 3'd7)) ? 3'd0 : m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_box_mover.sv
// Bouncing-box position: one step per frame start on each axis, reversing at
// the screen edges.
`default_nettype none

module pattern_box_mover
    import pattern_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 1
) (
    input  logic               clk_pix,
    input  logic               rst_in,
    input  logic               fs,
    input  logic [COORD_W-1:0] screen_width,
    input  logic [COORD_W-1:0] screen_height,
    output logic [COORD_W-1:0] bx,
    output logic [COORD_W-1:0] by
);

    localparam logic [COORD_W-1:0] STEP  = COORD_W'(BOX_STEP);
    localparam logic [COORD_W:0]   REACH = (COORD_W+1)'(BOX_SIZE + BOX_STEP);

    logic [COORD_W-1:0] pos      [2];
    box_dir_e           dir      [2];
    logic [COORD_W-1:0] extent   [2];
    logic [COORD_W:0]   far_edge [2];
    logic [COORD_W-1:0] pos_nxt  [2];
    box_dir_e           dir_nxt  [2];

    assign extent[0] = screen_width;
    assign extent[1] = screen_height;

    // Extra top bit on far_edge keeps the edge test free of wraparound.
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            far_edge[a] = {1'b0, pos[a]} + REACH;
            pos_nxt[a]  = pos[a];
            dir_nxt[a]  = dir[a];
            if (dir[a] == DIR_POS) begin
                if (far_edge[a] > {1'b0, extent[a]}) begin
                    dir_nxt[a] = DIR_NEG;
                    pos_nxt[a] = pos[a] - STEP;
                end else begin
                    pos_nxt[a] = pos[a] + STEP;
                end
            end else begin
                if (pos[a] < STEP) begin
                    dir_nxt[a] = DIR_POS;
                    pos_nxt[a] = pos[a] + STEP;
                end else begin
                    pos_nxt[a] = pos[a] - STEP;
                end
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_in) begin
            for (int a = 0; a < 2; a++) begin
                pos[a] <= '0;
                dir[a] <= DIR_POS;
            end
        end else if (fs) begin
            for (int a = 0; a < 2; a++) begin
                pos[a] <= pos_nxt[a];
                dir[a] <= dir_nxt[a];
            end
        end
    end

    assign bx = pos[0];
    assign by = pos[1];

endmodule

`default_nettype wire

// File: rtl/pattern_gen.sv
// Test-pattern generator: one registered RGB pixel per clk_pix from the HDMI
// core's frame coordinates; the pattern is selected at frame start.
`default_nettype none

module pattern_gen
    import pattern_pkg::*;
#(
    parameter int COORD_W  = 10,
    parameter int BPC      = 8,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 1
) (
    input  logic                 clk_pix,
    input  logic                 rst_in,
    input  logic [COORD_W-1:0]   cx,
    input  logic [COORD_W-1:0]   cy,
    input  logic [COORD_W-1:0]   screen_start_x,
    input  logic [COORD_W-1:0]   screen_start_y,
    input  logic [COORD_W-1:0]   screen_width,
    input  logic [COORD_W-1:0]   screen_height,
    input  logic [2:0]           mode_in,
    input  logic [3*BPC-1:0]     solid_color,
    output logic [3*BPC-1:0]     rgb,
    output logic                 rgb_valid,
    output logic [2:0]           mode_active,
    output logic [15:0]          frame_cnt
);

    typedef struct packed {
        logic [BPC-1:0] r;
        logic [BPC-1:0] g;
        logic [BPC-1:0] b;
    } rgb_t;

    localparam logic [COORD_W:0] BOX_EXT = (COORD_W+1)'(BOX_SIZE);

    // 8-bit channel values are left-aligned into BPC bits.
    function automatic logic [BPC-1:0] widen8(input logic [7:0] c);
        logic [BPC-1:0] t;
        t = BPC'(c);
        return t << (BPC - 8);
    endfunction

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               active;
    logic               fs;
    logic [2:0]         mode_eff;

    assign x        = cx - screen_start_x;
    assign y        = cy - screen_start_y;
    assign active   = (cx >= screen_start_x) && (cy >= screen_start_y);
    assign fs       = (cx == '0) && (cy == '0);
    assign mode_eff = fs ? map_mode(mode_in) : mode_active;

    logic [COORD_W-1:0] bx;
    logic [COORD_W-1:0] by;

    pattern_box_mover #(
        .COORD_W  (COORD_W),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box_mover (
        .clk_pix       (clk_pix),
        .rst_in        (rst_in),
        .fs            (fs),
        .screen_width  (screen_width),
        .screen_height (screen_height),
        .bx            (bx),
        .by            (by)
    );

    logic [COORD_W-1:0] bw;
    logic [COORD_W-1:0] run_cnt;
    logic [COORD_W-1:0] run_cnt_cur;
    logic [COORD_W-1:0] run_cnt_nxt;
    logic [2:0]         bar_idx;
    logic [2:0]         bar_idx_cur;
    logic [2:0]         bar_idx_nxt;
    logic [2:0]         bar_sel;

    // Bars are tracked by a run-length counter instead of dividing x by bw;
    // the last bar saturates and absorbs any remainder columns.
    always_comb begin
        bw          = screen_width >> 3;
        run_cnt_cur = run_cnt;
        bar_idx_cur = bar_idx;
        if (x == '0) begin
            run_cnt_cur = '0;
            bar_idx_cur = '0;
        end
        run_cnt_nxt = run_cnt_cur + 1'b1;
        bar_idx_nxt = bar_idx_cur;
        if ((run_cnt_nxt == bw) && (bar_idx_cur != 3'd7)) begin
            run_cnt_nxt = '0;
            bar_idx_nxt = bar_idx_cur + 3'd1;
        end
        bar_sel = (bw == '0) ? 3'd7 : bar_idx_cur;
    end

    logic [COORD_W:0] xw;
    logic [COORD_W:0] yw;
    logic [COORD_W:0] bxw;
    logic [COORD_W:0] byw;
    logic             in_box;

    assign xw     = {1'b0, x};
    assign yw     = {1'b0, y};
    assign bxw    = {1'b0, bx};
    assign byw    = {1'b0, by};
    assign in_box = (xw >= bxw) && (xw < bxw + BOX_EXT) &&
                    (yw >= byw) && (yw < byw + BOX_EXT);

    logic [7:0] leg_r;
    logic [7:0] leg_g;
    logic [7:0] leg_b;
    bar_rgb_t   bar_col;
    rgb_t       pix;

    always_comb begin
        leg_r   = {cx[5:0] & {6{cy[4:3] == ~cx[4:3]}}, 2'b00};
        leg_g   = cx[7:0] & {8{cy[6]}};
        leg_b   = cy[7:0];
        bar_col = BAR_TABLE[bar_sel];
        pix     = '0;
        case (pat_mode_e'(mode_eff))
            PAT_LEGACY: begin
                pix.r = widen8(leg_r);
                pix.g = widen8(leg_g);
                pix.b = widen8(leg_b);
            end
            PAT_BARS: begin
                pix.r = widen8(bar_col.r);
                pix.g = widen8(bar_col.g);
                pix.b = widen8(bar_col.b);
            end
            PAT_RAMP: begin
                pix.r = BPC'(x);
                pix.g = BPC'(x);
                pix.b = BPC'(x);
            end
            PAT_SOLID: pix = solid_color;
            PAT_BOX:   pix = in_box ? '1 : '0;
            default:   pix = '0;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_in) begin
            rgb         <= '0;
            rgb_valid   <= 1'b0;
            mode_active <= '0;
            frame_cnt   <= '0;
            bar_idx     <= '0;
            run_cnt     <= '0;
        end else begin
            rgb       <= active ? pix : '0;
            rgb_valid <= active;
            if (fs) begin
                mode_active <= map_mode(mode_in);
                frame_cnt   <= frame_cnt + 16'd1;
            end
            if (active) begin
                bar_idx <= bar_idx_nxt;
                run_cnt <= run_cnt_nxt;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: the driver queues expected pixels, the
// monitor pops and compares one entry per clock.
`default_nettype none

module tb_pattern_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [9:0]  cx, cy;
    logic [9:0]  ssx, ssy, sw, sh;
    logic [2:0]  mode_in;
    logic [23:0] solid8;
    logic [29:0] solid10;

    logic [23:0] rgb8;
    logic        vld8;
    logic [2:0]  mode8;
    logic [15:0] fc8;
    logic [29:0] rgb10;
    logic        vld10;
    logic [2:0]  mode10;
    logic [15:0] fc10;

    pattern_gen #(.COORD_W(10), .BPC(8), .BOX_SIZE(32), .BOX_STEP(1)) dut8 (
        .clk_pix(clk), .rst_in(rst_n), .cx(cx), .cy(cy),
        .screen_start_x(ssx), .screen_start_y(ssy),
        .screen_width(sw), .screen_height(sh),
        .mode_in(mode_in), .solid_color(solid8),
        .rgb(rgb8), .rgb_valid(vld8), .mode_active(mode8), .frame_cnt(fc8)
    );

    pattern_gen #(.COORD_W(10), .BPC(10), .BOX_SIZE(32), .BOX_STEP(1)) dut10 (
        .clk_pix(clk), .rst_in(rst_n), .cx(cx), .cy(cy),
        .screen_start_x(ssx), .screen_start_y(ssy),
        .screen_width(sw), .screen_height(sh),
        .mode_in(mode_in), .solid_color(solid10),
        .rgb(rgb10), .rgb_valid(vld10), .mode_active(mode10), .frame_cnt(fc10)
    );

    typedef struct {
        bit          chk;
        logic [23:0] rgb;
        logic        vld;
        bit          chk_mode;
        logic [2:0]  mode;
        bit          chk_fc;
        logic [15:0] fc;
        bit          chk10;
        logic [29:0] rgb10;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   tag_n = 0;

    function automatic exp_t mk(bit c, logic [23:0] r, logic v,
                                bit cm, logic [2:0] m, bit cf, logic [15:0] f);
        exp_t e;
        e.chk = c; e.rgb = r; e.vld = v;
        e.chk_mode = cm; e.mode = m;
        e.chk_fc = cf; e.fc = f;
        e.chk10 = 1'b0; e.rgb10 = '0; e.tag = 0;
        return e;
    endfunction

    function automatic exp_t px(logic [23:0] r);
        return mk(1'b1, r, 1'b1, 1'b0, 3'd0, 1'b0, 16'd0);
    endfunction

    function automatic exp_t nochk();
        return mk(1'b0, 24'd0, 1'b0, 1'b0, 3'd0, 1'b0, 16'd0);
    endfunction

    // Hand-picked columns of the bar row (bar width 80, start column 160).
    function automatic exp_t bar_exp(int c);
        case (c)
            160, 239: return px(24'hFFFFFF);
            240, 319: return px(24'hFFFF00);
            320:      return px(24'h00FFFF);
            719:      return px(24'h0000FF);
            720, 799: return px(24'h000000);
            default:  return nochk();
        endcase
    endfunction

    task automatic cmp(input string what, input int tag,
                       input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s #%0d: got %0h expected %0h", what, tag, act, want);
        end
    endtask

    task automatic step(input logic [9:0] x_, input logic [9:0] y_,
                        input bit rst_low, input logic [2:0] m, input exp_t e);
        @(negedge clk);
        rst_n   = !rst_low;
        cx      = x_;
        cy      = y_;
        mode_in = m;
        e.tag   = tag_n++;
        q.push_back(e);
    endtask

    // Monitor: one registered output per cycle, sampled after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    cmp("rgb", e.tag, {8'd0, rgb8}, {8'd0, e.rgb});
                    cmp("rgb_valid", e.tag, {31'd0, vld8}, {31'd0, e.vld});
                end
                if (e.chk_mode) cmp("mode_active", e.tag, {29'd0, mode8}, {29'd0, e.mode});
                if (e.chk_fc)   cmp("frame_cnt", e.tag, {16'd0, fc8}, {16'd0, e.fc});
                if (e.chk10)    cmp("rgb_bpc10", e.tag, {2'd0, rgb10}, {2'd0, e.rgb10});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n   = 1'b0;
        cx      = '0;
        cy      = '0;
        ssx     = 10'd160;
        ssy     = 10'd45;
        sw      = 10'd640;
        sh      = 10'd480;
        mode_in = 3'd0;
        solid8  = 24'h123456;
        solid10 = {10'h3FF, 10'h000, 10'h155};

        repeat (3) step(10'd0, 10'd0, 1'b1, 3'd0, mk(1, 24'h0, 1'b0, 1, 3'd0, 1, 16'd0));

        // Frame 1: colour bars
        step(10'd0, 10'd0, 1'b0, 3'd1, mk(1, 24'h0, 1'b0, 1, 3'd1, 1, 16'd1));
        step(10'd100, 10'd100, 1'b0, 3'd5, mk(1, 24'h0, 1'b0, 1, 3'd1, 1, 16'd1));
        for (int c = 160; c < 800; c++) step(10'(c), 10'd100, 1'b0, 3'd0, bar_exp(c));

        // Frame 2: legacy checker/gradient, both channel widths
        step(10'd0, 10'd0, 1'b0, 3'd0, mk(1, 24'h0, 1'b0, 1, 3'd0, 1, 16'd2));
        e = px(24'h00C848); e.chk10 = 1'b1; e.rgb10 = {10'h000, 10'h320, 10'h120};
        step(10'd200, 10'd72, 1'b0, 3'd3, e);
        e = px(24'h40D048); e.chk10 = 1'b1; e.rgb10 = {10'h100, 10'h340, 10'h120};
        step(10'd208, 10'd72, 1'b0, 3'd3, e);
        step(10'd200, 10'd100, 1'b0, 3'd3, mk(1, 24'h00C864, 1'b1, 1, 3'd0, 1, 16'd2));

        // Frame 3: solid colour takes effect only after the frame start
        step(10'd0, 10'd0, 1'b0, 3'd3, mk(1, 24'h0, 1'b0, 1, 3'd3, 1, 16'd3));
        e = px(24'h123456); e.chk10 = 1'b1; e.rgb10 = {10'h3FF, 10'h000, 10'h155};
        step(10'd160, 10'd45, 1'b0, 3'd0, e);

        // Frame 4: code 7 maps back to legacy
        step(10'd0, 10'd0, 1'b0, 3'd7, mk(1, 24'h0, 1'b0, 1, 3'd0, 1, 16'd4));
        step(10'd208, 10'd72, 1'b0, 3'd4, px(24'h40D048));

        // Frame 5: box at (5,5)
        step(10'd0, 10'd0, 1'b0, 3'd4, mk(1, 24'h0, 1'b0, 1, 3'd4, 1, 16'd5));
        step(10'd165, 10'd50, 1'b0, 3'd4, px(24'hFFFFFF));
        step(10'd164, 10'd50, 1'b0, 3'd4, px(24'h000000));
        step(10'd165, 10'd49, 1'b0, 3'd4, px(24'h000000));

        // Mid-frame reset
        repeat (2) step(10'd300, 10'd200, 1'b1, 3'd4, mk(1, 24'h0, 1'b0, 1, 3'd0, 1, 16'd0));
        step(10'd300, 10'd200, 1'b0, 3'd4, mk(1, 24'h002CC8, 1'b1, 1, 3'd0, 1, 16'd0));

        // Box restarts from (0,0): after 3 frame starts it sits at (3,3)
        for (int i = 1; i <= 3; i++)
            step(10'd0, 10'd0, 1'b0, 3'd4, mk(1, 24'h0, 1'b0, 1, 3'd4, 1, 16'(i)));
        step(10'd163, 10'd48, 1'b0, 3'd4, px(24'hFFFFFF));
        step(10'd162, 10'd48, 1'b0, 3'd4, px(24'h000000));

        // Back-to-back frame starts up to 609: x bounced at 608 -> 607, y at 287
        for (int i = 4; i <= 609; i++)
            step(10'd0, 10'd0, 1'b0, 3'd4, mk(i == 609, 24'h0, 1'b0, 0, 3'd4, 1, 16'(i)));
        step(10'd767, 10'd332, 1'b0, 3'd4, px(24'hFFFFFF));
        step(10'd766, 10'd332, 1'b0, 3'd4, px(24'h000000));
        step(10'd798, 10'd332, 1'b0, 3'd4, px(24'hFFFFFF));
        step(10'd799, 10'd332, 1'b0, 3'd4, px(24'h000000));
        step(10'd767, 10'd331, 1'b0, 3'd4, px(24'h000000));

        // One more frame: both axes now moving negative, box at (606,286)
        step(10'd0, 10'd0, 1'b0, 3'd4, mk(1, 24'h0, 1'b0, 1, 3'd4, 1, 16'd610));
        step(10'd766, 10'd331, 1'b0, 3'd4, px(24'hFFFFFF));
        step(10'd798, 10'd331, 1'b0, 3'd4, px(24'h000000));

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
